// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared types and constants for the 4x4 matrix keypad scanner.
//   - KEYMAP      : hex code for each (row, column) position, Pmod KYPD layout
//   - scan_res_t  : classification of one complete four-row scan
//   - kp_state_t  : debounce state of the accepted key
// -----------------------------------------------------------------------------
package keypad_pkg;

  // Row 0 is the top row, column 0 is the leftmost column.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_res_t;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } kp_state_t;

endpackage

// File: rtl/keypad_row_scanner.sv
// -----------------------------------------------------------------------------
// keypad_row_scanner
//   Drives the keypad rows one at a time (active-low), synchronises the column
//   lines, samples them once per row slot and classifies each complete scan.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     col_in     in   [3:0] raw keypad columns, active-low, asynchronous
//     row_out    out  [3:0] row drive, exactly one bit low
//     scan_done  out  high for the single cycle that closes a scan (row 3 sample)
//     scan_res   out  NONE / SINGLE / MULTI for the scan closing this cycle
//     scan_code  out  [3:0] key code, meaningful when scan_res == SINGLE
// -----------------------------------------------------------------------------
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       scan_done,
  output scan_res_t  scan_res,
  output logic [3:0] scan_code
);

  localparam int                 DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [3:0]       row_q;

  // Accumulated over rows 0..2 of the current scan: count of low bits
  // (0, 1, or 2 meaning "many") and the position of the single one.
  logic [1:0]       acc_n;
  logic [1:0]       acc_r;
  logic [1:0]       acc_c;

  logic             sample;
  logic [1:0]       row_n;
  logic [1:0]       row_c;
  logic [2:0]       sum_n;
  logic [1:0]       tot_n;
  logic [1:0]       tot_r;
  logic [1:0]       tot_c;

  // Two-flop synchroniser; idle columns read high, so reset to all ones.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // The sample is taken on the last cycle of a row slot, which leaves the
  // preceding cycles for the keypad to settle and the synchroniser to fill.
  assign sample = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      row_idx <= 2'd0;
      row_q   <= 4'b1110;
    end else if (sample) begin
      div     <= '0;
      row_idx <= row_idx + 2'd1;
      row_q   <= {row_q[2:0], row_q[3]};
    end else begin
      div     <= div + DIV_W'(1);
    end
  end

  assign row_out = row_q;

  // Count the low columns of the row being sampled (saturating at 2).
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    row_n = 2'd0;
    row_c = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync[c]) begin
        if (row_n != 2'd2) row_n = row_n + 2'd1;
        row_c = 2'(c);
      end
    end
  end

  // Combine this row with the rows already seen in this scan.
  always_comb begin
    sum_n = {1'b0, acc_n} + {1'b0, row_n};
    tot_n = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_r = acc_r;
    tot_c = acc_c;
    if (row_n == 2'd1) begin
      tot_r = row_idx;
      tot_c = row_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n <= 2'd0;
      acc_r <= 2'd0;
      acc_c <= 2'd0;
    end else if (sample) begin
      if (row_idx == 2'd3) begin
        acc_n <= 2'd0;
        acc_r <= 2'd0;
        acc_c <= 2'd0;
      end else begin
        acc_n <= tot_n;
        acc_r <= tot_r;
        acc_c <= tot_c;
      end
    end
  end

  assign scan_done = sample && (row_idx == 2'd3);
  assign scan_code = KEYMAP[tot_r][tot_c];

  always_comb begin
    scan_res = MULTI;
    if (tot_n == 2'd0)      scan_res = NONE;
    else if (tot_n == 2'd1) scan_res = SINGLE;
  end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   4x4 matrix keypad front end: row scanning, column synchronisation,
//   whole-scan debouncing and one hex key code per accepted press.
//   Rollover (two or more keys down) never produces a press.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     col_in     in   [3:0] keypad columns, pulled up, active-low
//     row_out    out  [3:0] keypad rows, exactly one bit low
//     key_code   out  [3:0] code of the last accepted key (held)
//     key_valid  out  one-cycle pulse per accepted press
//     key_held   out  high while the accepted key is considered down
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic             scan_done;
  scan_res_t        scan_res;
  logic [3:0]       scan_code;

  kp_state_t        state;
  kp_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       cand;
  logic [3:0]       cand_nxt;
  logic             match;
  logic             accept;
  logic             release_key;

  keypad_row_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_row_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .scan_done (scan_done),
    .scan_res  (scan_res),
    .scan_code (scan_code)
  );

  // Scan counter saturates at the target so it can never wrap back to zero.
  assign cnt_inc = (cnt == CNT_TARGET) ? cnt : cnt + CNT_W'(1);
  assign match   = (scan_res == SINGLE) && (scan_code == cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt   <= '0;
      cand  <= 4'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // The FSM only moves on the cycle that closes a scan.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    accept      = 1'b0;
    release_key = 1'b0;
    if (scan_done) begin
      unique case (state)
        RELEASED: begin
          if (scan_res == SINGLE) begin
            cand_nxt = scan_code;
            cnt_nxt  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end else begin
              state_nxt = PRESS_PENDING;
            end
          end
        end
        PRESS_PENDING: begin
          if (match) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= CNT_TARGET) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end
          end else begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (!match) begin
            state_nxt = RELEASE_PENDING;
            cnt_nxt   = CNT_W'(1);
          end
        end
        RELEASE_PENDING: begin
          if (scan_res == NONE) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= CNT_TARGET) begin
              state_nxt   = RELEASED;
              cnt_nxt     = '0;
              release_key = 1'b1;
            end
          end else if (match) begin
            // The same key came back: resume without a second key_valid.
            state_nxt = PRESSED;
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_nxt;
        key_held <= 1'b1;
      end else if (release_key) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Keypad is modelled combinationally from row_out and a 16-bit "keys down"
//   mask (bit r*4+c). The stimulus process changes the mask only at scan
//   boundaries and, after each scan, runs a scan-level reference model of the
//   debounce rules, pushing the expected outputs for the cycle after the scan
//   ends. A monitor process compares the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = SCAN_DIV * 4;

  localparam logic [3:0] TB_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  localparam logic [15:0] K_1 = 16'h0001;  // row 0 col 0
  localparam logic [15:0] K_2 = 16'h0002;  // row 0 col 1
  localparam logic [15:0] K_5 = 16'h0020;  // row 1 col 1
  localparam logic [15:0] K_9 = 16'h0400;  // row 2 col 2
  localparam logic [15:0] K_D = 16'h8000;  // row 3 col 3

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys = 16'h0;
  longint      cyc = 0;
  int          rel_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    logic       held;
    longint     cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [3:0]  exp_row;

  // Reference model state (one step per complete scan).
  bit          m_held;
  bit          m_pend;
  int          m_run;
  logic [3:0]  m_cand;
  logic [3:0]  m_code;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_cyc <= 0;
    else        rel_cyc <= rel_cyc + 1;
  end

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_pend = 1'b0;
    m_run  = 0;
    m_cand = 4'h0;
    m_code = 4'h0;
  endtask

  task automatic model_accept();
    m_code = m_cand;
    m_held = 1'b1;
    m_pend = 1'b0;
  endtask

  // Debounce rules applied to one whole scan with the given keys down.
  task automatic model_scan(input logic [15:0] k, output logic v);
    int         n;
    int         idx;
    logic [3:0] code;
    bit         single;
    bit         match;
    n   = $countones(k);
    idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    code   = TB_MAP[idx];
    single = (n == 1);
    match  = single && (code == m_cand);
    v      = 1'b0;
    if (!m_held) begin
      if (!m_pend) begin
        if (single) begin
          m_cand = code;
          m_run  = 1;
          if (m_run >= DEB) begin model_accept(); v = 1'b1; end
          else m_pend = 1'b1;
        end
      end else if (match) begin
        m_run++;
        if (m_run >= DEB) begin model_accept(); v = 1'b1; end
      end else begin
        m_pend = 1'b0;
        m_run  = 0;
      end
    end else begin
      if (!m_pend) begin
        if (!match) begin m_pend = 1'b1; m_run = 1; end
      end else if (n == 0) begin
        m_run++;
        if (m_run >= DEB) begin m_held = 1'b0; m_pend = 1'b0; m_run = 0; end
      end else if (match) begin
        m_pend = 1'b0;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One full scan with a fixed key set; called at the first falling edge of
  // the scan and returns at the first falling edge of the next scan.
  task automatic run_scan(input logic [15:0] k);
    logic v;
    keys = k;
    repeat (SCAN_CYC - 1) @(negedge clk);
    model_scan(k, v);
    sb.push_back('{valid: v, code: m_code, held: m_held, cyc: cyc + 1});
    @(negedge clk);
  endtask

  task automatic run_scans(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_scan(k);
  endtask

  // Monitor: reset values, row rotation every cycle, scoreboard at scan ends.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      check("reset_row_out", row_out, 4'b1110);
      check("reset_key_code", key_code, 4'h0);
      check("reset_key_valid", key_valid, 1'b0);
      check("reset_key_held", key_held, 1'b0);
    end else begin
      exp_row = ~(4'b0001 << ((rel_cyc / SCAN_DIV) % 4));
      check("row_out", row_out, exp_row);
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        check("scan_end_key_valid", key_valid, mon_e.valid);
        check("scan_end_key_code", key_code, mon_e.code);
        check("scan_end_key_held", key_held, mon_e.held);
      end else begin
        check("idle_key_valid", key_valid, 1'b0);
      end
    end
  end

  initial begin
    logic [15:0] k;
    int          kind;
    int          len;
    int          a;
    int          b;

    // Reset and row rotation
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    run_scans(16'h0, 2);

    // Clean press of '5' held 6 scans, then release for 3 scans
    run_scans(K_5, 6);
    run_scans(16'h0, 3);

    // Bouncing '9': 2 present, 1 absent, 3 present, then release
    run_scans(K_9, 2);
    run_scans(16'h0, 1);
    run_scans(K_9, 3);
    run_scans(16'h0, 3);

    // Rollover '1'+'2' rejected, then '1' alone accepted
    run_scans(K_1 | K_2, 5);
    run_scans(K_1, 4);
    run_scans(16'h0, 3);

    // Async reset while 'D' is accepted and still down
    run_scans(K_D, 4);
    keys = K_D;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_scans(K_D, 4);
    run_scans(16'h0, 3);

    // Randomised scan sequences: idle, single keys, multi-key rollover
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      k    = 16'h0;
      case (kind)
        0:       k = 16'h0;
        4:       begin k[a] = 1'b1; k[b] = 1'b1; end
        default: k[a] = 1'b1;
      endcase
      run_scans(k, len);
    end
    run_scans(16'h0, 4);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
